// File: rtl/cm0_dap_cdc_recv_hs.sv
// Receive side of a four-phase CDC handshake for the DAP clock crossings.
// Synchronises the remote request level, captures the quasi-static data bus
// once the request is seen, and hands the word to local logic with
// valid/ready. The acknowledge back to the remote domain comes straight
// from a flop, so it cannot glitch.
//
// Ports:
//   REGCLK, REGRESETn  local clock, asynchronous active-low reset
//   SE                 scan enable (no functional effect)
//   REQASYNC           request level from the remote send register
//   DATAASYNC[DW]      remote data, stable while REQASYNC is high
//   ACKASYNC           acknowledge to the remote domain (flop output)
//   DATAOUT[DW]        captured word, held until the next capture
//   DATAVALID          DATAOUT holds an unconsumed word
//   DATAREADY          local consumer accepts the word
//   BUSY               handshake in progress
module cm0_dap_cdc_recv_hs #(
  parameter int unsigned DW          = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PRESENT     = 1
) (
  input  logic          REGCLK,
  input  logic          REGRESETn,
  input  logic          SE,
  input  logic          REQASYNC,
  input  logic [DW-1:0] DATAASYNC,
  output logic          ACKASYNC,
  output logic [DW-1:0] DATAOUT,
  output logic          DATAVALID,
  input  logic          DATAREADY,
  output logic          BUSY
);

  if (PRESENT != 0) begin : g_present

    typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_VALID = 2'd1,
      S_ACK   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_sync;
    logic                   ack_q, ack_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic [DW-1:0]          data_q, data_d;
    logic                   unused_se;

    assign unused_se = SE;

    // Request level synchroniser; only the last stage is used by the FSM.
    always_ff @(posedge REGCLK or negedge REGRESETn) begin
      if (!REGRESETn) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], REQASYNC};
      end
    end

    assign req_sync = sync_q[SYNC_STAGES-1];

    // State and output registers.
    always_ff @(posedge REGCLK or negedge REGRESETn) begin
      if (!REGRESETn) begin
        state_q <= S_IDLE;
        ack_q   <= 1'b0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
        data_q  <= '0;
      end else begin
        state_q <= state_d;
        ack_q   <= ack_d;
        valid_q <= valid_d;
        busy_q  <= busy_d;
        data_q  <= data_d;
      end
    end

    // Next state and next register values. DATAASYNC is sampled only when
    // req_sync is high, where the remote side guarantees it is stable.
    always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      valid_d = valid_q;
      data_d  = data_q;
      case (state_q)
        S_IDLE: begin
          if (req_sync) begin
            data_d  = DATAASYNC;
            valid_d = 1'b1;
            state_d = S_VALID;
          end
        end
        S_VALID: begin
          // A request drop here is a protocol violation and is ignored.
          if (DATAREADY) begin
            valid_d = 1'b0;
            ack_d   = 1'b1;
            state_d = S_ACK;
          end
        end
        S_ACK: begin
          if (!req_sync) begin
            ack_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          ack_d   = 1'b0;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      endcase
      // BUSY tracks the state register exactly (state != IDLE).
      busy_d = (state_d != S_IDLE);
    end

    assign ACKASYNC  = ack_q;
    assign DATAVALID = valid_q;
    assign DATAOUT   = data_q;
    assign BUSY      = busy_q;

  end else begin : g_absent

    logic unused_inputs;

    assign unused_inputs = ^{REGCLK, REGRESETn, SE, REQASYNC, DATAASYNC, DATAREADY};

    assign ACKASYNC  = 1'b0;
    assign DATAVALID = 1'b0;
    assign DATAOUT   = '0;
    assign BUSY      = 1'b0;

  end

endmodule

// File: doc/cm0_dap_cdc_recv_hs.md
# cm0_dap_cdc_recv_hs

Receive-side four-phase CDC handshake stage for the DAP clock-domain crossings. Sits directly downstream of the CDC-safe send registers in the remote domain: it synchronises the remote request level, captures the quasi-static data bus, and presents it to local logic with a valid/ready handshake. It returns a glitch-free, register-driven acknowledge that the remote domain synchronises in turn.

## Interface
- DW, 32, width of the crossing data bus (1..64)
- SYNC_STAGES, 2, flops in the request synchroniser (2..4)
- PRESENT, 1, 0 removes the block: all outputs tied 0, no state

- REGCLK  input  1  local domain clock
- REGRESETn  input  1  reset REGRESETn, asynchronous, active-low; clock REGCLK
- SE  input  1  DFT scan enable; no functional effect
- REQASYNC  input  1  request level from remote send register (asynchronous)
- DATAASYNC  input  DW  data from remote send registers; stable while REQASYNC high
- ACKASYNC  output  1  acknowledge to remote domain, driven only by a flop
- DATAOUT  output  DW  captured data, held until next capture
- DATAVALID  output  1  DATAOUT holds an unconsumed word
- DATAREADY  input  1  local consumer accepts the word
- BUSY  output  1  handshake in progress (state != IDLE)

## Operation
- Synchroniser: SYNC_STAGES flops, reset 0, clocked by REGCLK; last stage is req_sync. DATAASYNC is never synchronised; it is sampled only when req_sync=1, which the four-phase protocol guarantees is stable.
- State machine, 3 states, reset to IDLE:
  - IDLE: ACK=0, VALID=0. On edge with req_sync=1: DATAOUT<=DATAASYNC, DATAVALID<=1, go VALID.
  - VALID: hold DATAOUT, DATAVALID=1. On edge with DATAREADY=1: DATAVALID<=0, ACKASYNC<=1, go ACK.
  - ACK: ACKASYNC=1. On edge with req_sync=0: ACKASYNC<=0, go IDLE.
- BUSY=1 in VALID and ACK, 0 in IDLE (decoded from state register).
- ACKASYNC is a dedicated flop output, never combinational, and toggles only on the VALID->ACK and ACK->IDLE transitions; it does not glitch on any other edge.
- DATAOUT changes only on the IDLE->VALID capture edge.
- A req_sync drop while in VALID, which is a protocol violation, is ignored: the word is still delivered and ACK is still raised. On entering ACK with req_sync already 0, ACK drops on the next edge.
- PRESENT=0: synchroniser, state and data registers are absent; ACKASYNC, DATAOUT, DATAVALID and BUSY are constant 0.

## Timing
- Reset values: ACKASYNC=0, DATAVALID=0, DATAOUT=0, BUSY=0, synchroniser=0, state=IDLE.
- Request latency: REQASYNC is first sampled high at edge E0. req_sync=1 after edge E0+SYNC_STAGES-1. DATAVALID=1 and DATAOUT are valid after edge E0+SYNC_STAGES.
- Accept: the edge with DATAVALID=1 and DATAREADY=1 clears DATAVALID and sets ACKASYNC on the same edge. DATAREADY may be held high permanently, giving 1 cycle in VALID.
- Release: REQASYNC first sampled low at edge E1. ACKASYNC=0 after edge E1+SYNC_STAGES.
- Minimum local cost per transfer with DATAREADY=1 is 2*SYNC_STAGES+2 cycles, excluding remote-domain delay.
- A new request is recognised only from IDLE. Back-to-back transfers need REQASYNC low to be observed before the next high.
- Reset mid-operation: all outputs return to reset values immediately, asynchronously. If REQASYNC is still high after reset release, it is re-synchronised and the held data is captured again (a duplicate word). System-level reset sequencing must prevent this.

## Test plan
- Single transfer, SYNC_STAGES=2, DATAREADY=1: REQASYNC rises with DATAASYNC=32'hA5A5_0F0F. Required: DATAVALID after 2 edges with DATAOUT=32'hA5A5_0F0F, ACKASYNC=1 one edge later. Drop REQASYNC; ACKASYNC=0 two edges later and BUSY=0.
- Backpressure: DATAREADY=0 for 10 cycles after DATAVALID. Required: DATAVALID and DATAOUT held and ACKASYNC=0 throughout; ACKASYNC rises on the first edge with DATAREADY=1.
- Back-to-back: 8 transfers, data 0..7, with a remote model driving the four-phase protocol and random DATAREADY. Required: 8 words in order, no duplicates, and ACKASYNC never changes outside the two allowed transitions (checked every edge).
- Data churn: DATAASYNC toggles while REQASYNC is low and the state is IDLE. Required: DATAOUT unchanged and DATAVALID=0.
- Reset mid-operation: assert REGRESETn low in VALID and in ACK. Required: all outputs 0 within the same cycle. With REQASYNC held high across reset, one recapture occurs SYNC_STAGES+1 edges after release.
- PRESENT=0 and SYNC_STAGES=4 builds: for PRESENT=0, all outputs 0 under any stimulus. For SYNC_STAGES=4, capture latency is 4 edges and release latency is 4 edges.
